// File: rtl/axi_rr_arb_node.sv
// Round-robin arbitration node: combinational select/forward, pointer advances past the winner on each transfer.
// Optional AXI_RR_ARB_LOCK_EN holds a stalled winner (selection and payload stable) until its transfer completes.
module axi_rr_arb_node #(
  parameter int N_INPUTS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = $clog2(N_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_INPUTS-1:0]            req_i,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] data_i,
  output logic [N_INPUTS-1:0]            gnt_o,
  output logic                           req_o,
  output logic [DATA_WIDTH-1:0]          data_o,
  input  logic                           gnt_i,
  output logic [PTR_WIDTH-1:0]           sel_o,
  output logic [PTR_WIDTH-1:0]           rr_flag_o
);

  localparam logic [PTR_WIDTH:0] N_EXT = N_INPUTS[PTR_WIDTH:0];

  logic [PTR_WIDTH-1:0] rr_flag;
  logic [PTR_WIDTH-1:0] win;
  logic [PTR_WIDTH:0]   cand;
  logic [PTR_WIDTH:0]   ptr_inc;
  logic                 found;
  logic                 xfer;

  // Candidates stay below 2*N_INPUTS, so one conditional subtract is a full modulo.
  always_comb begin
    found = 1'b0;
    win   = rr_flag;
    cand  = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      cand = {1'b0, rr_flag} + (PTR_WIDTH+1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && req_i[cand[PTR_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = cand[PTR_WIDTH-1:0];
      end
    end
  end

`ifdef AXI_RR_ARB_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state, state_nxt;
  logic [PTR_WIDTH-1:0] lock_idx, lock_idx_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_idx_nxt = lock_idx;
    sel_o        = win;
    req_o        = |req_i;
    case (state)
      IDLE: begin
        if (req_o && !gnt_i) begin
          state_nxt    = LOCKED;
          lock_idx_nxt = win;
        end
      end
      LOCKED: begin
        // A dropped request while locked is an upstream violation: stall, keep the lock.
        sel_o = lock_idx;
        req_o = req_i[lock_idx];
        if (req_o && gnt_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
`else
  always_comb begin
    sel_o = win;
    req_o = |req_i;
  end
`endif

  always_comb begin
    data_o = '0;
    gnt_o  = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      if (sel_o == PTR_WIDTH'(k)) begin
        data_o   = data_i[k*DATA_WIDTH +: DATA_WIDTH];
        gnt_o[k] = gnt_i & req_o;
      end
    end
  end

  assign xfer    = req_o & gnt_i;
  assign ptr_inc = {1'b0, sel_o} + {{PTR_WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_flag <= '0;
    end else if (xfer) begin
      rr_flag <= (ptr_inc >= N_EXT) ? '0 : ptr_inc[PTR_WIDTH-1:0];
    end
  end

  assign rr_flag_o = rr_flag;

endmodule

// File: tb/tb_axi_rr_arb_node.sv
// Bench for axi_rr_arb_node: table vectors, hand-written lock/reset sequences, N_INPUTS=3 rotation, random vs model.
module tb_axi_rr_arb_node;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] data;
  logic [3:0]   gnt_o;
  logic         req_o;
  logic [31:0]  data_o;
  logic         gnt;
  logic [1:0]   sel;
  logic [1:0]   rr;

  logic [2:0]   req3;
  logic [95:0]  data3;
  logic [2:0]   gnt3_o;
  logic         req3_o;
  logic [31:0]  data3_o;
  logic         gnt3;
  logic [1:0]   sel3;
  logic [1:0]   rr3;

  int n_cmp;
  int n_bad;

  // Reference model state: pointer as a plain integer, lock as a flag plus index.
  int         m_ptr;
  bit         m_locked;
  logic [1:0] m_lk;

  typedef struct {
    logic [3:0] req;
    logic       gnt;
    logic [1:0] sel;
    logic [3:0] gnt_o;
    logic [1:0] rr;
    logic       req_o;
  } vec_t;

  axi_rr_arb_node #(.N_INPUTS(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_i(req), .data_i(data), .gnt_o(gnt_o),
    .req_o(req_o), .data_o(data_o), .gnt_i(gnt), .sel_o(sel), .rr_flag_o(rr)
  );

  axi_rr_arb_node #(.N_INPUTS(3), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .rst(rst), .req_i(req3), .data_i(data3), .gnt_o(gnt3_o),
    .req_o(req3_o), .data_o(data3_o), .gnt_i(gnt3), .sel_o(sel3), .rr_flag_o(rr3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval(output logic [1:0] es, output logic er, output logic [3:0] eg);
    es = 2'(m_ptr);
    er = |req;
    if (m_locked) begin
      es = m_lk;
      er = req[m_lk];
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req[(m_ptr + i) % 4]) begin
          es = 2'((m_ptr + i) % 4);
          break;
        end
      end
    end
    eg = (er && gnt) ? (4'b0001 << es) : 4'b0000;
  endtask

  // One clock cycle: check at the falling edge, advance the model at the rising edge.
  task automatic step(input string tag, input vec_t v, input bit use_v);
    logic [1:0] es;
    logic       er;
    logic [3:0] eg;
    if (rst) begin
      m_ptr    = 0;
      m_locked = 0;
      m_lk     = 2'd0;
    end
    model_eval(es, er, eg);
    @(negedge clk);
    chk({tag, "_sel"},   32'(sel),    32'(es));
    chk({tag, "_req_o"}, 32'(req_o),  32'(er));
    chk({tag, "_gnt_o"}, 32'(gnt_o),  32'(eg));
    chk({tag, "_rr"},    32'(rr),     32'(m_ptr));
    chk({tag, "_data"},  data_o,      data[es*32 +: 32]);
    if (use_v) begin
      chk({tag, "_vsel"},  32'(sel),   32'(v.sel));
      chk({tag, "_vgnt"},  32'(gnt_o), 32'(v.gnt_o));
      chk({tag, "_vrr"},   32'(rr),    32'(v.rr));
      chk({tag, "_vreq"},  32'(req_o), 32'(v.req_o));
    end
    @(posedge clk);
    if (!rst) begin
      if (er && gnt) begin
        m_ptr    = (int'(es) + 1) % 4;
        m_locked = 0;
      end
`ifdef AXI_RR_ARB_LOCK_EN
      else if (er && !gnt && !m_locked) begin
        m_locked = 1;
        m_lk     = es;
      end
`endif
    end
    #1;
  endtask

  task automatic apply(input string tag, input vec_t v);
    req = v.req;
    gnt = v.gnt;
    step(tag, v, 1'b1);
  endtask

  vec_t tbl[9];
  vec_t hv;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_ptr = 0;
    m_locked = 0;
    m_lk = 2'd0;
    rst  = 1'b1;
    req  = 4'b1111;
    gnt  = 1'b0;
    data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    req3 = 3'b000;
    gnt3 = 1'b0;
    data3 = {32'hB2, 32'hB1, 32'hB0};

    // Full rotation after reset, then sparse alternation, then idle.
    tbl[0] = '{4'b1111, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1};
    tbl[1] = '{4'b1111, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b1};
    tbl[2] = '{4'b1111, 1'b1, 2'd2, 4'b0100, 2'd2, 1'b1};
    tbl[3] = '{4'b1111, 1'b1, 2'd3, 4'b1000, 2'd3, 1'b1};
    tbl[4] = '{4'b1111, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1};
    tbl[5] = '{4'b1010, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b1};
    tbl[6] = '{4'b1010, 1'b1, 2'd3, 4'b1000, 2'd2, 1'b1};
    tbl[7] = '{4'b1010, 1'b1, 2'd1, 4'b0010, 2'd0, 1'b1};
    tbl[8] = '{4'b0000, 1'b0, 2'd2, 4'b0000, 2'd2, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rr",    32'(rr),     32'd0);
    chk("rst_sel",   32'(sel),    32'd0);
    chk("rst_gnt_o", 32'(gnt_o),  32'd0);
    chk("rst_req_o", 32'(req_o),  32'd1);
    chk("rst_rr3",   32'(rr3),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 9; i++) apply($sformatf("tbl%0d", i), tbl[i]);

    // Non-power-of-two rotation on the 3-input node.
    req3 = 3'b111;
    gnt3 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("n3_sel%0d", i),  32'(sel3),    32'(i % 3));
      chk($sformatf("n3_gnt%0d", i),  32'(gnt3_o),  32'(3'b001 << (i % 3)));
      chk($sformatf("n3_data%0d", i), data3_o,      32'hB0 + 32'(i % 3));
      chk($sformatf("n3_rr%0d", i),   32'(rr3),     32'(i % 3));
      @(posedge clk);
      #1;
    end
    req3 = 3'b000;
    gnt3 = 1'b0;

    // Lock sequence from a freshly reset pointer.
    rst = 1'b1;
    req = 4'b0000;
    gnt = 1'b0;
    step("lrst", hv, 1'b0);
    rst = 1'b0;
    apply("lk0", '{4'b0100, 1'b0, 2'd2, 4'b0000, 2'd0, 1'b1});
`ifdef AXI_RR_ARB_LOCK_EN
    apply("lk1", '{4'b0101, 1'b0, 2'd2, 4'b0000, 2'd0, 1'b1});
    apply("lk2", '{4'b0101, 1'b1, 2'd2, 4'b0100, 2'd0, 1'b1});
    apply("lk3", '{4'b0101, 1'b1, 2'd0, 4'b0001, 2'd3, 1'b1});
    apply("lk4", '{4'b0000, 1'b0, 2'd1, 4'b0000, 2'd1, 1'b0});
    apply("rl0", '{4'b0100, 1'b0, 2'd2, 4'b0000, 2'd1, 1'b1});
    apply("rl1", '{4'b0110, 1'b0, 2'd2, 4'b0000, 2'd1, 1'b1});
`else
    apply("lk1", '{4'b0101, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b1});
    apply("lk2", '{4'b0101, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b1});
    apply("lk3", '{4'b0101, 1'b1, 2'd2, 4'b0100, 2'd1, 1'b1});
    apply("lk4", '{4'b0000, 1'b0, 2'd3, 4'b0000, 2'd3, 1'b0});
    apply("rl0", '{4'b0100, 1'b0, 2'd2, 4'b0000, 2'd3, 1'b1});
    apply("rl1", '{4'b0110, 1'b0, 2'd1, 4'b0000, 2'd3, 1'b1});
`endif
    // Reset pulse while (possibly) locked: lock dropped, lowest asserted index wins.
    rst = 1'b1;
    apply("rl2", '{4'b0110, 1'b0, 2'd1, 4'b0000, 2'd0, 1'b1});
    rst = 1'b0;
    apply("rl3", '{4'b0110, 1'b1, 2'd1, 4'b0010, 2'd0, 1'b1});

    // Randomized traffic, occasional reset and payload change.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      req = 4'($urandom_range(0, 15));
      gnt = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) data = {$urandom, $urandom, $urandom, $urandom};
      step("rnd", hv, 1'b0);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
